// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Execute/writeback boundary stage sitting directly after the combinational ALU.
//   Each accepted ALU op is decoded into a writeback entry and queued in a
//   2-entry FIFO with valid/ready handshakes on both sides. The stage owns the
//   HI/LO product registers (loaded from the full A*B product on a multiply op),
//   resolves BEQ/BNE and produces register-file write enables.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid / in_ready            upstream handshake (in_ready = buffer not full)
//   in_opcode, in_a, in_b          opcode and operands driven to the ALU
//   in_alu_out                     ALU result
//   in_zero, in_neg, in_ovf        ALU flags
//   in_rd                          destination register index
//   out_valid / out_ready          writeback handshake on the head entry
//   out_result, out_rd             head entry result and destination
//   out_wr_en                      write out_result to out_rd
//   out_is_addr                    result is a memory address (opcodes 5-9)
//   out_br_taken                   branch resolved taken (opcodes 10/11)
//   flags                          {ovf,neg,zero} of the last accepted op
//   hi, lo                         architectural HI/LO registers
module alu_result_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  input  logic [DATA_W-1:0]     in_alu_out,
  input  logic                  in_zero,
  input  logic                  in_neg,
  input  logic                  in_ovf,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wr_en,
  output logic                  out_is_addr,
  output logic                  out_br_taken,
  output logic [2:0]            flags,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo
);

  localparam int PROD_W = 2 * DATA_W;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr_en;
    logic                  is_addr;
    logic                  br_taken;
  } entry_t;

  logic [PROD_W-1:0] prod_p0;
  entry_t            ent_p0;
  logic [2:0]        flags_nxt_p0;
  logic              push;
  logic              pop;

  entry_t            buf_p1 [2];
  entry_t            head_p1;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [2:0]        flags_q;

  // Stage p0: decode the incoming ALU op into a writeback entry
  assign prod_p0 = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};

  always_comb begin
    ent_p0       = '0;
    ent_p0.rd    = in_rd;
    flags_nxt_p0 = {in_ovf, in_neg, in_zero};
    case (in_opcode)
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
        ent_p0.result  = in_alu_out;
        ent_p0.is_addr = 1'b1;
      end
      4'd10: ent_p0.br_taken = (in_a == in_b);
      4'd11: ent_p0.br_taken = (in_a != in_b);
      4'd12: begin
        ent_p0.result = hi_q;
        ent_p0.wr_en  = 1'b1;
        flags_nxt_p0  = {1'b0, hi_q[DATA_W-1], (hi_q == '0)};
      end
      4'd13: begin
        ent_p0.result   = in_alu_out;
        ent_p0.wr_en    = 1'b1;
        flags_nxt_p0[2] = |prod_p0[PROD_W-1:DATA_W];
      end
      4'd14: begin
        ent_p0.result = lo_q;
        ent_p0.wr_en  = 1'b1;
        flags_nxt_p0  = {1'b0, lo_q[DATA_W-1], (lo_q == '0)};
      end
      default: begin
        ent_p0.result = in_alu_out;
        ent_p0.wr_en  = 1'b1;
      end
    endcase
  end

  // in_ready depends on occupancy only, so a pop in the same cycle never
  // opens a slot while full (no bypass path from out_ready to in_ready).
  assign in_ready = (count < 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Stage p1: 2-entry output buffer and architectural state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        flags_q <= flags_nxt_p0;
        if (in_opcode == 4'd13) begin
          hi_q <= prod_p0[PROD_W-1:DATA_W];
          lo_q <= prod_p0[DATA_W-1:0];
        end
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Entry storage carries no reset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) buf_p1[wr_ptr] <= ent_p0;
  end

  assign head_p1      = buf_p1[rd_ptr];
  assign out_valid    = (count != 2'd0);
  assign out_result   = out_valid ? head_p1.result : '0;
  assign out_rd       = out_valid ? head_p1.rd     : '0;
  assign out_wr_en    = out_valid && head_p1.wr_en;
  assign out_is_addr  = out_valid && head_p1.is_addr;
  assign out_br_taken = out_valid && head_p1.br_taken;
  assign flags        = flags_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule
